// File: rtl/ave8_pkg.sv
// Shared types and constants for the three-digit BCD display path.
package ave8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 3;
  localparam int ACC_W      = BCD_W * NUM_DIGITS;

  localparam logic [BCD_W-1:0] BLANK_CODE_DEFAULT = 4'hF;

  // Double-dabble correction: a nibble of 5..9 becomes 8..12, so no carry out.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bcd_shift_step.sv
// One double-dabble step: per-nibble add-3, then shift left with the next binary bit.
module bcd_shift_step
  import ave8_pkg::*;
(
  input  logic [ACC_W-1:0] acc_in,
  input  logic             msb_in,
  output logic [ACC_W-1:0] acc_out
);

  logic [ACC_W-1:0] adj;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign adj[gi*BCD_W +: BCD_W] = add3(acc_in[gi*BCD_W +: BCD_W]);
  end

  assign acc_out = {adj[ACC_W-2:0], msb_in};

endmodule

// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD display controller feeding three seven-segment decoders.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module bcd_display_ctrl
  import ave8_pkg::*;
#(
  parameter int               IN_W       = 8,
  parameter logic [BCD_W-1:0] BLANK_CODE = BLANK_CODE_DEFAULT
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [IN_W-1:0]  in_value,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             freeze,
  output logic [BCD_W-1:0] digit_units,
  output logic [BCD_W-1:0] digit_tens,
  output logic [BCD_W-1:0] digit_hun,
  output logic             upd_pulse,
  output logic             busy
);

  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [BCD_W-1:0] RST_HUN  = BLANK_CODE;
  localparam logic [BCD_W-1:0] RST_TENS = BLANK_CODE;
`else
  localparam logic [BCD_W-1:0] RST_HUN  = '0;
  localparam logic [BCD_W-1:0] RST_TENS = '0;
`endif

  state_t           state_reg, state_next;
  logic [IN_W-1:0]  sr_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_step;
  logic [CNT_W-1:0] cnt_reg;
  logic [BCD_W-1:0] hun_new, tens_new;

  bcd_shift_step u_step (
    .acc_in  (acc_reg),
    .msb_in  (sr_reg[IN_W-1]),
    .acc_out (acc_step)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (cnt_reg == CNT_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);

`ifdef LEADING_ZERO_BLANK_EN
  assign hun_new  = (acc_reg[11:8] == 4'd0) ? BLANK_CODE : acc_reg[11:8];
  assign tens_new = (acc_reg[11:8] == 4'd0 && acc_reg[7:4] == 4'd0) ? BLANK_CODE : acc_reg[7:4];
`else
  assign hun_new  = acc_reg[11:8];
  assign tens_new = acc_reg[7:4];
`endif

  // All three digits load on the same edge so the display never mixes results.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sr_reg      <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      digit_hun   <= RST_HUN;
      digit_tens  <= RST_TENS;
      digit_units <= '0;
      upd_pulse   <= 1'b0;
    end else begin
      upd_pulse <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sr_reg  <= in_value;
            acc_reg <= '0;
            cnt_reg <= '0;
          end
        end
        SHIFT: begin
          acc_reg <= acc_step;
          sr_reg  <= sr_reg << 1;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        DONE: begin
          if (!freeze) begin
            digit_hun   <= hun_new;
            digit_tens  <= tens_new;
            digit_units <= acc_reg[3:0];
            upd_pulse   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Self-checking bench for bcd_display_ctrl: countdown reference model plus directed literal checks.
module tb_bcd_display_ctrl;

  localparam int IN_W = 8;

  logic            CLOCK = 1'b0;
  logic            RESET;
  logic [IN_W-1:0] in_value;
  logic            in_valid;
  logic            in_ready;
  logic            freeze;
  logic [3:0]      digit_units, digit_tens, digit_hun;
  logic            upd_pulse;
  logic            busy;

  int n_cmp  = 0;
  int n_fail = 0;
  bit checking = 0;

  bcd_display_ctrl #(.IN_W(IN_W), .BLANK_CODE(4'hF)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .in_value    (in_value),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .freeze      (freeze),
    .digit_units (digit_units),
    .digit_tens  (digit_tens),
    .digit_hun   (digit_hun),
    .upd_pulse   (upd_pulse),
    .busy        (busy)
  );

  always #5 CLOCK = ~CLOCK;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  // Expected display nibbles for a binary value, straight from decimal arithmetic.
  function automatic logic [11:0] expect_digits(input int v);
    int h, t, u;
    logic [3:0] hh, tt;
    h = v / 100; t = (v / 10) % 10; u = v % 10;
    hh = 4'(h); tt = 4'(t);
    if (BLANK && h == 0) hh = 4'hF;
    if (BLANK && h == 0 && t == 0) tt = 4'hF;
    return {hh, tt, 4'(u)};
  endfunction

  // Reference model: a countdown of IN_W+1 edges from acceptance to the display update.
  int         m_cd = 0;
  int         m_pend = 0;
  logic [11:0] m_dig;
  logic       m_upd = 1'b0;
  int         m_accepts = 0;
  int         m_updates = 0;
  int         act_updates = 0;

  always @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      m_cd  = 0;
      m_dig = BLANK ? 12'hFF0 : 12'h000;
      m_upd = 1'b0;
    end else begin
      m_upd = 1'b0;
      if (m_cd == 0) begin
        if (in_valid === 1'b1) begin
          m_pend = int'(in_value);
          m_cd   = IN_W + 1;
          m_accepts++;
        end
      end else begin
        m_cd--;
        if (m_cd == 0 && freeze !== 1'b1) begin
          m_dig = expect_digits(m_pend);
          m_upd = 1'b1;
          m_updates++;
        end
      end
    end
  end

  always @(negedge CLOCK) begin
    if (checking) begin
      logic [14:0] act, exp_v;
      act   = {digit_hun, digit_tens, digit_units, upd_pulse, busy, in_ready};
      exp_v = {m_dig, m_upd, (m_cd != 0), (m_cd == 0)};
      n_cmp++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL model t=%0t hun/tens/units/upd/busy/rdy got %h/%h/%h/%b/%b/%b want %h/%h/%h/%b/%b/%b",
                 $time, act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
                 exp_v[14:11], exp_v[10:7], exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
      end
      if (upd_pulse === 1'b1) act_updates++;
    end
  end

  task automatic check_lit(input string name, input logic [3:0] h, input logic [3:0] t,
                           input logic [3:0] u, input logic upd);
    n_cmp++;
    if ({digit_hun, digit_tens, digit_units, upd_pulse} !== {h, t, u, upd}) begin
      n_fail++;
      $display("FAIL %s got %h/%h/%h upd=%b want %h/%h/%h upd=%b",
               name, digit_hun, digit_tens, digit_units, upd_pulse, h, t, u, upd);
    end
  endtask

  // Offer a sample until accepted; returns 1 time unit after the acceptance edge.
  task automatic send(input int v, input bit hold);
    bit rdy;
    bit ok = 0;
    in_value = IN_W'(v);
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLOCK); rdy = in_ready;
      @(posedge CLOCK); #1;
      if (rdy) ok = 1;
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout value=%0d in_ready stayed low, want high within 40 cycles", v);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  // Wait through IN_W shift edges and the DONE edge; optionally garble inputs during SHIFT.
  task automatic wait_done(input bit garble);
    for (int i = 0; i <= IN_W; i++) begin
      @(posedge CLOCK); #1;
      if (garble) begin
        if (i < IN_W - 1) begin
          in_valid = 1'($urandom);
          in_value = IN_W'($urandom);
        end else in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached, want completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] zb;
    zb = BLANK ? 4'hF : 4'h0;
    RESET = 1'b1; in_valid = 1'b0; in_value = '0; freeze = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    check_lit("reset_digits", zb, zb, 4'd0, 1'b0);
    RESET = 1'b0;
    checking = 1;

    send(255, 1);
    in_valid = 1'b0;
    wait_done(0);
    check_lit("conv_255", 4'd2, 4'd5, 4'd5, 1'b1);

    send(0, 1);   wait_done(0); check_lit("b2b_0",   zb, zb, 4'd0, 1'b1);
    send(7, 1);   wait_done(0); check_lit("b2b_7",   zb, zb, 4'd7, 1'b1);
    send(100, 0); wait_done(0); check_lit("b2b_100", 4'd1, 4'd0, 4'd0, 1'b1);

    send(42, 0); wait_done(0); check_lit("show_42", zb, 4'd4, 4'd2, 1'b1);
    send(199, 0);
    repeat (IN_W) @(posedge CLOCK);
    #1 freeze = 1'b1;
    @(posedge CLOCK); #1 freeze = 1'b0;
    check_lit("freeze_hold", zb, 4'd4, 4'd2, 1'b0);
    send(199, 0); wait_done(0); check_lit("after_freeze_199", 4'd1, 4'd9, 4'd9, 1'b1);

    send(77, 0); wait_done(1); check_lit("garble_77", zb, 4'd7, 4'd7, 1'b1);

    send(255, 0);
    repeat (4) @(posedge CLOCK);
    #2 RESET = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset busy=%b in_ready=%b want busy=0 in_ready=1", busy, in_ready);
    end
    check_lit("async_reset_digits", zb, zb, 4'd0, 1'b0);
    #1 RESET = 1'b0;
    send(128, 0); wait_done(0); check_lit("after_reset_128", 4'd1, 4'd2, 4'd8, 1'b1);

    for (int v = 0; v < 256; v++) begin
      send(v, 0);
      wait_done(0);
    end

    for (int i = 0; i < 2000; i++) begin
      @(posedge CLOCK); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      in_value = IN_W'($urandom);
      freeze   = ($urandom_range(0, 3) == 0);
    end
    in_valid = 1'b0; freeze = 1'b0;
    repeat (IN_W + 4) @(posedge CLOCK);
    @(negedge CLOCK); #1;

    n_cmp++;
    if (act_updates != m_updates) begin
      n_fail++;
      $display("FAIL upd_count got %0d pulses want %0d (accepted %0d)", act_updates, m_updates, m_accepts);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
